// File: rtl/key_pkg.sv
// Shared types and default timing constants for the pushbutton conditioner.
// Optional auto-repeat is enabled with the KEY_REPEAT_EN macro.
package key_pkg;

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } key_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int REPEAT_DELAY_DEF    = 25000000;
    localparam int REPEAT_PERIOD_DEF   = 5000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce_pulse_sync.sv
// Two-flop synchronizer with a configurable reset value.
// Generic; usable for any asynchronous board input.
module sync_2ff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces an active-low key into a held level and a one-cycle press strobe.
// Defining KEY_REPEAT_EN adds auto-repeat strobes while the key is held.
module key_debounce_pulse
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_pulse,
    output logic o_level,
    output logic o_repeating
);

    localparam int CNT_W =
        $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic       key_q;
    logic       key_s;
    key_state_t state;
    key_state_t state_nx;
    cnt_t       cnt;
    cnt_t       cnt_nx;
    logic       level_nx;
    logic       pulse_nx;
    logic       press;

    sync_2ff #(
        .W      (1),
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(i_clk),
        .rst(i_rst),
        .d  (i_key_n),
        .q  (key_q)
    );

    assign key_s = ~key_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_RELEASED;
            cnt     <= '0;
            o_level <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            o_level <= level_nx;
            o_pulse <= pulse_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = o_level;
        press    = 1'b0;
        unique case (state)
            S_RELEASED: begin
                if (key_s) begin
                    state_nx = S_PRESS_WAIT;
                    cnt_nx   = cnt_t'(1);
                end
            end
            S_PRESS_WAIT: begin
                if (!key_s) begin
                    state_nx = S_RELEASED;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = S_PRESSED;
                    cnt_nx   = '0;
                    level_nx = 1'b1;
                    press    = 1'b1;
                end else begin
                    cnt_nx = sat_inc(cnt);
                end
            end
            S_PRESSED: begin
                if (!key_s) begin
                    state_nx = S_RELEASE_WAIT;
                    cnt_nx   = cnt_t'(1);
                end
            end
            S_RELEASE_WAIT: begin
                if (key_s) begin
                    state_nx = S_PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = S_RELEASED;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                end else begin
                    cnt_nx = sat_inc(cnt);
                end
            end
            default: begin
                state_nx = S_RELEASED;
                cnt_nx   = '0;
            end
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam cnt_t RD_LAST = cnt_t'(REPEAT_DELAY - 1);
    localparam cnt_t RP_LAST = cnt_t'(REPEAT_PERIOD - 1);

    cnt_t hold;
    cnt_t hold_nx;
    logic rep;
    logic rep_nx;
    logic rep_fire;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold <= '0;
            rep  <= 1'b0;
        end else begin
            hold <= hold_nx;
            rep  <= rep_nx;
        end
    end

    // Timer only advances while stably pressed; release bounces freeze it.
    always_comb begin
        hold_nx  = hold;
        rep_nx   = rep;
        rep_fire = 1'b0;
        if (press || state_nx == S_RELEASED) begin
            hold_nx = '0;
            rep_nx  = 1'b0;
        end else if (state == S_PRESSED && key_s) begin
            if (!rep && hold == RD_LAST) begin
                rep_fire = 1'b1;
                rep_nx   = 1'b1;
                hold_nx  = '0;
            end else if (rep && hold == RP_LAST) begin
                rep_fire = 1'b1;
                hold_nx  = '0;
            end else begin
                hold_nx = sat_inc(hold);
            end
        end
    end

    assign pulse_nx    = press | rep_fire;
    assign o_repeating = rep;
`else
    assign pulse_nx    = press;
    assign o_repeating = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with short debounce/repeat timing.
// Repeat expectations follow KEY_REPEAT_EN when the bench is built with it.
module tb_key_debounce_pulse;

    logic clk = 1'b0;
    logic i_rst;
    logic i_key_n;
    logic o_pulse;
    logic o_level;
    logic o_repeating;

    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse = -1;
    int consec = 0;
    int hi_cyc = 0;
    int lo_cyc = 0;
    logic prev_pulse = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

`ifdef KEY_REPEAT_EN
    localparam int REP_ON = 1;
`else
    localparam int REP_ON = 0;
`endif

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_key_n    (i_key_n),
        .o_pulse    (o_pulse),
        .o_level    (o_level),
        .o_repeating(o_repeating)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_pulse) begin
                pulse_cnt  = pulse_cnt + 1;
                last_pulse = cyc;
                if (prev_pulse) consec = consec + 1;
            end
            if (o_level) hi_cyc = hi_cyc + 1;
            else lo_cyc = lo_cyc + 1;
            prev_pulse = o_pulse;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int e;
    int r;
    int base;
    int hi0;
    int lo0;

    initial begin
        i_rst   = 1'b1;
        i_key_n = 1'b1;
        step(2);
        chk("rst_pulse", o_pulse, 0);
        chk("rst_level", o_level, 0);
        chk("rst_rep", o_repeating, 0);
        i_rst = 1'b0;
        step(5);
        chk("idle_level", o_level, 0);
        chk("idle_pulses", pulse_cnt, 0);

        // clean press then release
        base = pulse_cnt;
        e = cyc;
        i_key_n = 1'b0;
        step(5);
        chk("t1_lvl_pre", o_level, 0);
        chk("t1_pls_pre", o_pulse, 0);
        step(1);
        chk("t1_pls", o_pulse, 1);
        chk("t1_lvl", o_level, 1);
        step(1);
        chk("t1_pls_off", o_pulse, 0);
        step(13);
        chk("t1_cnt", pulse_cnt - base, 1);
        chk("t1_when", last_pulse, e + 6);
        i_key_n = 1'b1;
        step(5);
        chk("t1_rel_pre", o_level, 1);
        step(1);
        chk("t1_rel", o_level, 0);
        step(4);
        chk("t1_rel_nopls", pulse_cnt - base, 1);

        // bouncing press
        base = pulse_cnt;
        hi0 = hi_cyc;
        for (int i = 0; i < 10; i++) begin
            i_key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        chk("t2_bounce_pls", pulse_cnt - base, 0);
        chk("t2_bounce_lvl", hi_cyc - hi0, 0);
        e = cyc;
        i_key_n = 1'b0;
        step(10);
        chk("t2_cnt", pulse_cnt - base, 1);
        chk("t2_when", last_pulse, e + 6);
        chk("t2_lvl", o_level, 1);
        i_key_n = 1'b1;
        step(8);
        chk("t2_rel", o_level, 0);

        // short glitch rejected
        base = pulse_cnt;
        hi0 = hi_cyc;
        i_key_n = 1'b0;
        step(3);
        i_key_n = 1'b1;
        step(10);
        chk("t3_pls", pulse_cnt - base, 0);
        chk("t3_lvl", hi_cyc - hi0, 0);

        // release glitch while held
        base = pulse_cnt;
        i_key_n = 1'b0;
        step(7);
        chk("t4_held", o_level, 1);
        lo0 = lo_cyc;
        i_key_n = 1'b1;
        step(2);
        i_key_n = 1'b0;
        step(3);
        chk("t4_lvl", o_level, 1);
        chk("t4_nodrop", lo_cyc - lo0, 0);
        chk("t4_cnt", pulse_cnt - base, 1);
        i_key_n = 1'b1;
        step(8);
        chk("t4_rel", o_level, 0);

        // reset during press-wait
        i_key_n = 1'b0;
        step(3);
        i_rst = 1'b1;
        #1;
        chk("t5_inrst_pls", o_pulse, 0);
        chk("t5_inrst_lvl", o_level, 0);
        step(2);
        i_rst = 1'b0;
        r = cyc;
        base = pulse_cnt;
        step(5);
        chk("t5_pre", pulse_cnt - base, 0);
        step(1);
        chk("t5_pls", o_pulse, 1);
        step(1);
        chk("t5_pls_off", o_pulse, 0);
        step(5);
        chk("t5_cnt", pulse_cnt - base, 1);
        chk("t5_when", last_pulse, r + 6);
        i_key_n = 1'b1;
        step(8);
        chk("t5_rel", o_level, 0);

        // long hold: repeat behaviour
        base = pulse_cnt;
        i_key_n = 1'b0;
        step(15);
        chk("t6_rep_pre", o_repeating, 0);
        step(1);
        chk("t6_rep_on", o_repeating, REP_ON);
        chk("t6_rep_pls", o_pulse, REP_ON);
        step(24);
        i_key_n = 1'b1;
        step(20);
        chk("t6_cnt", pulse_cnt - base, REP_ON ? 7 : 1);
        chk("t6_rep_off", o_repeating, 0);
        chk("t6_lvl", o_level, 0);
        chk("no_consec", consec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
- Conditions a raw, bouncing, active-low DE2 pushbutton into clean control signals.
- Produces the single-cycle start strobe consumed by the random-number block's start input, plus a debounced held level.
- Sits between the board key pins and any FSM that requires exactly one pulse per physical press.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or release (1 ms at 50 MHz); legal range is 2 or more.
- REPEAT_DELAY, 25000000, cycles a press must be held before auto-repeat starts. Used only with KEY_REPEAT_EN.
- REPEAT_PERIOD, 5000000, cycles between auto-repeat pulses. Used only with KEY_REPEAT_EN.
- CNT_W, $clog2(max of the three above)+1, internal counter width; derived, not overridden.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-high reset
- i_key_n  input  1  raw pushbutton, 0 = pressed, asynchronous to i_clk
- o_pulse  output  1  one-cycle strobe per accepted press (and per repeat when enabled)
- o_level  output  1  debounced key state, 1 = held
- o_repeating  output  1  1 while auto-repeat is active; tied to 0 without KEY_REPEAT_EN

Behaviour:
- Reset:
  - o_pulse=0, o_level=0, o_repeating=0.
  - Counter=0, FSM=S_RELEASED, synchronizer flops = 1 (released).
  - Reset asserted mid-press aborts everything; no pulse is issued on deassertion even if the key is still held. A fresh debounce from S_RELEASED follows.
- Synchronizer:
  - i_key_n passes through 2 flops. key_s = inverted output of the 2nd flop (1 = pressed).
- FSM states: S_RELEASED, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT.
- S_RELEASED:
  - key_s=1: go to S_PRESS_WAIT, counter=1.
- S_PRESS_WAIT:
  - key_s=0: back to S_RELEASED, counter=0. Any bounce restarts.
  - key_s=1 and counter==DEBOUNCE_CYCLES-1: go to S_PRESSED; o_level<=1 and o_pulse<=1 on the same edge.
  - Otherwise counter+1.
- S_PRESSED:
  - key_s=0: go to S_RELEASE_WAIT, counter=1.
- S_RELEASE_WAIT:
  - key_s=1: back to S_PRESSED, counter=0, no new pulse.
  - key_s=0 and counter==DEBOUNCE_CYCLES-1: go to S_RELEASED, o_level<=0.
- o_pulse:
  - Registered; high exactly one cycle, then 0.
  - Never asserted on release.
  - Never asserted in two consecutive cycles.
- Latency:
  - Raw falling edge sampled at edge N: key_s=1 after edge N+1.
  - o_pulse and o_level rise after edge N+1+DEBOUNCE_CYCLES.
  - Release is symmetric, with no pulse.
- Width and wrap:
  - Counter is CNT_W bits and saturates; it never wraps.
  - Counter is cleared on every state change.
- A glitch shorter than DEBOUNCE_CYCLES produces no output change in either direction.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - While in S_PRESSED, a hold counter runs.
  - At REPEAT_DELAY cycles after the press pulse: o_pulse fires and o_repeating<=1.
  - Further o_pulse every REPEAT_PERIOD cycles thereafter.
  - Entering S_RELEASE_WAIT freezes the repeat timer without pulsing.
  - Returning to S_PRESSED from a bounce resumes the timer.
  - Reaching S_RELEASED clears o_repeating and the timer.
- Undefined:
  - No hold counter is synthesized.
  - o_repeating is constant 0.
  - Exactly one pulse per press.

Decomposition:
- Package key_pkg:
  - key_state_t enum {S_RELEASED, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT}.
  - Default constants DEBOUNCE_CYCLES_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF.
- Sub-module sync_2ff:
  - Parameterized reset value.
  - Async active-high reset.
  - Reused for other board inputs.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Clean press: i_key_n 1→0 sampled at edge 10, held 20 cycles → o_pulse=1 only during cycle after edge 15, o_level=1 from edge 15. Release → o_level=0 4+2 cycles after the raw rise, no pulse.
- Bounce: i_key_n toggles 0/1 every 2 cycles for 20 cycles, then steady 0 → exactly one o_pulse, 6 cycles after the last transition.
- Glitch rejection: i_key_n low for 3 cycles only → o_pulse and o_level stay 0.
- Release glitch: while held, i_key_n high for 2 cycles → o_level stays 1, no second o_pulse.
- Reset mid-operation: i_rst=1 during S_PRESS_WAIT, then deasserted with key still held → counting restarts, pulse appears 6 cycles after reset release, never twice.
- KEY_REPEAT_EN: hold 40 cycles → pulses at press, press+10, press+15, press+20, … while held; o_repeating=1 from press+10; after release o_repeating=0 once S_RELEASED is reached.
